// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the fetch-side PC sequencer.
package pc_seq_pkg;

  localparam int unsigned PC_WIDTH = 32;
  localparam logic [PC_WIDTH-1:0] DEFAULT_RESET_PC = '0;

  typedef enum logic [1:0] {
    BOOT,
    IDLE,
    FETCH,
    KILL
  } seq_state_e;

endpackage

// File: rtl/pc_sequencer_pcmux.sv
// 2:1 next-PC mux: sequential PC or redirect target.
module pc_sequencer_pcmux
  import pc_seq_pkg::*;
#(
  parameter int unsigned WIDTH = PC_WIDTH
) (
  input  logic             sel_i,
  input  logic [WIDTH-1:0] seq_pc_i,
  input  logic [WIDTH-1:0] branch_pc_i,
  output logic [WIDTH-1:0] pc_o
);

  assign pc_o = sel_i ? branch_pc_i : seq_pc_i;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch controller: owns the PC, issues req/ack fetches, and applies branch
// redirects, including ones that land while a fetch is still in flight.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned      WIDTH    = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC),
  parameter logic [WIDTH-1:0] INC      = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             branch_valid_i,
  input  logic [WIDTH-1:0] branch_target_i,
  output logic             imem_req_o,
  output logic [WIDTH-1:0] imem_addr_o,
  input  logic             imem_ack_i,
  output logic [WIDTH-1:0] pc_o,
  output logic             pc_valid_o,
  output logic             pc_sel_o,
  output logic             flush_o
);

  seq_state_e       state_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pending_target_q;
  logic             pending_valid_q;
  logic [WIDTH-1:0] pc_out_q;
  logic             pc_valid_q;
  logic             pc_sel_q;
  logic             flush_q;

  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] redirect_target;
  logic             redirect_sel;
  logic [WIDTH-1:0] pc_d;

  // A same-cycle branch always beats a redirect parked while the fetch drains.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pc_inc          = pc_q + INC;
    redirect_target = branch_target_i;
    if (pending_valid_q && !branch_valid_i) begin
      redirect_target = pending_target_q;
    end
    redirect_sel = branch_valid_i || pending_valid_q;
  end

  pc_sequencer_pcmux #(
    .WIDTH(WIDTH)
  ) u_pcmux (
    .sel_i      (redirect_sel),
    .seq_pc_i   (pc_inc),
    .branch_pc_i(redirect_target),
    .pc_o       (pc_d)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side sees the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= BOOT;
      pc_q             <= RESET_PC;
      pending_target_q <= RESET_PC;
      pending_valid_q  <= 1'b0;
      pc_out_q         <= RESET_PC;
      pc_valid_q       <= 1'b0;
      pc_sel_q         <= 1'b0;
      flush_q          <= 1'b0;
    end else begin
      pc_valid_q <= 1'b0;
      flush_q    <= 1'b0;
      unique case (state_q)
        BOOT: state_q <= IDLE;

        IDLE: begin
          if (branch_valid_i) begin
            pc_q     <= pc_d;
            pc_sel_q <= 1'b1;
            flush_q  <= 1'b1;
            state_q  <= stall_i ? IDLE : FETCH;
          end else if (!stall_i) begin
            state_q <= FETCH;
          end
        end

        FETCH: begin
          if (imem_ack_i) begin
            pc_q     <= pc_d;
            pc_sel_q <= branch_valid_i;
            if (branch_valid_i) begin
              flush_q <= 1'b1;
            end else begin
              pc_valid_q <= 1'b1;
              pc_out_q   <= pc_q;
            end
            state_q <= stall_i ? IDLE : FETCH;
          end else if (branch_valid_i) begin
            pending_target_q <= branch_target_i;
            pending_valid_q  <= 1'b1;
            state_q          <= KILL;
          end
        end

        KILL: begin
          // The address must stay put until ack, so the redirect waits here.
          if (imem_ack_i) begin
            pc_q            <= pc_d;
            pending_valid_q <= 1'b0;
            pc_sel_q        <= 1'b1;
            flush_q         <= 1'b1;
            state_q         <= stall_i ? IDLE : FETCH;
          end else if (branch_valid_i) begin
            pending_target_q <= branch_target_i;
          end
        end

        default: state_q <= BOOT;
      endcase
    end
  end

  assign imem_req_o  = (state_q == FETCH) || (state_q == KILL);
  assign imem_addr_o = pc_q;
  assign pc_o        = pc_out_q;
  assign pc_valid_o  = pc_valid_q;
  assign pc_sel_o    = pc_sel_q;
  assign flush_o     = flush_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised and directed bench for pc_sequencer; two instances differ only in
// RESET_PC and are checked every cycle against a transaction-level model.
module tb_pc_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         stall_i = 1'b0;
  logic         branch_valid_i = 1'b0;
  logic [W-1:0] branch_target_i = '0;
  logic         imem_ack_i = 1'b0;

  logic [1:0]   req, valid, sel, flush;
  logic [W-1:0] addr_a, addr_b, pco_a, pco_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pc_sequencer dut_a (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_i        (stall_i),
    .branch_valid_i (branch_valid_i),
    .branch_target_i(branch_target_i),
    .imem_req_o     (req[0]),
    .imem_addr_o    (addr_a),
    .imem_ack_i     (imem_ack_i),
    .pc_o           (pco_a),
    .pc_valid_o     (valid[0]),
    .pc_sel_o       (sel[0]),
    .flush_o        (flush[0])
  );

  pc_sequencer #(.RESET_PC(32'hFFFF_FFFF)) dut_b (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_i        (stall_i),
    .branch_valid_i (branch_valid_i),
    .branch_target_i(branch_target_i),
    .imem_req_o     (req[1]),
    .imem_addr_o    (addr_b),
    .imem_ack_i     (imem_ack_i),
    .pc_o           (pco_b),
    .pc_valid_o     (valid[1]),
    .pc_sel_o       (sel[1]),
    .flush_o        (flush[1])
  );

  // Reference model: "started" = first cycle after reset elapsed, "busy" = a
  // request is outstanding, "kill" = that request will be thrown away.
  bit           m_started, m_busy, m_kill, m_valid, m_flush, m_sel;
  logic [W-1:0] m_pend;
  logic [W-1:0] m_pc [2];
  logic [W-1:0] m_pco[2];

  function automatic logic [W-1:0] rst_pc(input int i);
    return (i == 0) ? 32'h0000_0000 : 32'hFFFF_FFFF;
  endfunction

  task automatic model_reset();
    m_started = 0; m_busy = 0; m_kill = 0;
    m_valid = 0; m_flush = 0; m_sel = 0;
    m_pend = '0;
    for (int i = 0; i < 2; i++) begin
      m_pc[i]  = rst_pc(i);
      m_pco[i] = rst_pc(i);
    end
  endtask

  task automatic model_redirect(input logic [W-1:0] t);
    for (int i = 0; i < 2; i++) m_pc[i] = t;
    m_sel   = 1;
    m_flush = 1;
  endtask

  task automatic model_step(input bit stall, input bit bv, input logic [W-1:0] bt,
                            input bit ack);
    m_valid = 0;
    m_flush = 0;
    if (!m_started) begin
      m_started = 1;
    end else if (!m_busy) begin
      if (bv) model_redirect(bt);
      m_busy = !stall;
    end else if (ack) begin
      if (m_kill || bv) begin
        model_redirect(bv ? bt : m_pend);
      end else begin
        m_valid = 1;
        m_sel   = 0;
        for (int i = 0; i < 2; i++) begin
          m_pco[i] = m_pc[i];
          m_pc[i]  = m_pc[i] + 32'd1;
        end
      end
      m_kill = 0;
      m_busy = !stall;
    end else if (bv) begin
      m_pend = bt;
      m_kill = 1;
    end
  endtask

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got=%h want=%h", tag, $time, got, exp);
    end
  endtask

  task automatic compare_all();
    check("req_a",   W'(req[0]),   W'(m_busy));
    check("req_b",   W'(req[1]),   W'(m_busy));
    check("addr_a",  addr_a,       m_pc[0]);
    check("addr_b",  addr_b,       m_pc[1]);
    check("pc_a",    pco_a,        m_pco[0]);
    check("pc_b",    pco_b,        m_pco[1]);
    check("valid_a", W'(valid[0]), W'(m_valid));
    check("valid_b", W'(valid[1]), W'(m_valid));
    check("sel_a",   W'(sel[0]),   W'(m_sel));
    check("sel_b",   W'(sel[1]),   W'(m_sel));
    check("flush_a", W'(flush[0]), W'(m_flush));
    check("flush_b", W'(flush[1]), W'(m_flush));
  endtask

  // Called just after a falling edge: drive, clock once, then compare.
  task automatic step(input bit stall, input bit bv, input logic [W-1:0] bt, input bit ack);
    stall_i         = stall;
    branch_valid_i  = bv;
    branch_target_i = bt;
    imem_ack_i      = ack;
    model_step(stall, bv, bt, ack);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic reset_mid_cycle();
    #2 rst_n = 1'b0;
    #1;
    check("req_drop_a", W'(req[0]), '0);
    check("req_drop_b", W'(req[1]), '0);
    model_reset();
    stall_i = 0; branch_valid_i = 0; imem_ack_i = 0;
    @(negedge clk);
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] tgt;
    bit           stall, bv, ack;

    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // Sequential fetches 0..3, each acked one cycle after the request shows.
    step(0, 0, '0, 0);
    step(0, 0, '0, 0);
    repeat (4) begin
      step(0, 0, '0, 0);
      step(0, 0, '0, 1);
    end

    // Stalled return to IDLE, then branch while idle, then release.
    step(1, 0, '0, 1);
    step(1, 1, 32'h100, 0);
    step(1, 0, '0, 0);
    step(0, 0, '0, 0);

    // Redirect onto address 5, then branch mid-fetch with a late ack.
    step(0, 1, 32'h5, 1);
    step(0, 1, 32'h40, 0);
    step(0, 0, '0, 0);
    step(0, 0, '0, 0);
    step(0, 0, '0, 1);

    // Two branches while the fetch drains: latest target wins.
    step(0, 1, 32'h40, 0);
    step(0, 1, 32'h80, 0);
    step(0, 0, '0, 1);

    // Branch coincident with ack at address 7.
    step(0, 1, 32'h7, 1);
    step(0, 1, 32'h20, 1);

    // Wrap through the top of the address space.
    step(0, 1, 32'hFFFF_FFFF, 1);
    step(0, 0, '0, 1);
    step(0, 0, '0, 0);

    // Reset while a request is outstanding.
    reset_mid_cycle();
    step(0, 0, '0, 0);
    step(0, 0, '0, 0);
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);

    for (int n = 0; n < 3000; n++) begin
      stall = ($urandom_range(0, 3) == 0);
      bv    = ($urandom_range(0, 6) == 0);
      case ($urandom_range(0, 3))
        0:       tgt = 32'hFFFF_FFFF;
        1:       tgt = W'($urandom_range(0, 255));
        default: tgt = $urandom;
      endcase
      ack = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      step(stall, bv, tgt, ack);
      if (n % 1000 == 999 && m_busy) reset_mid_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
